// File: rtl/dcache_writeback_buffer_if.sv
// Bundle between the L1 data cache, main memory and the writeback buffer.
// Ports: evict_* (line handoff), mm_* (word write bus), busy/done status,
//        snoop_* (refill probe). The buffer uses the slave modport; the
//        cache/memory side uses master.
interface dcache_writeback_buffer_if #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 32
);
    logic                  evict_valid;
    logic                  evict_ready;
    logic [ADDR_W-1:0]     evict_addr;
    logic [32*WORDS-1:0]   evict_data;
    logic                  mm_we;
    logic [ADDR_W-1:0]     mm_addr;
    logic [31:0]           mm_din;
    logic                  mm_ack;
    logic                  busy;
    logic                  done;
    logic [ADDR_W-1:0]     snoop_addr;
    logic                  snoop_hit;
    logic [31:0]           snoop_data;

    modport master (
        output evict_valid, evict_addr, evict_data, mm_ack, snoop_addr,
        input  evict_ready, mm_we, mm_addr, mm_din, busy, done,
               snoop_hit, snoop_data
    );

    modport slave (
        input  evict_valid, evict_addr, evict_data, mm_ack, snoop_addr,
        output evict_ready, mm_we, mm_addr, mm_din, busy, done,
               snoop_hit, snoop_data
    );
endinterface

// File: rtl/dcache_writeback_buffer.sv
// Holds one evicted dirty line and drains it to memory a word at a time,
// with a combinational snoop port so refills see the newest data.
// Ports: CLK, RST (async, active-high), wb (slave side of the bundle:
//        evict handshake in, memory write bus out, status, snoop probe).
module dcache_writeback_buffer #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 32
) (
    input  logic CLK,
    input  logic RST,
    dcache_writeback_buffer_if.slave wb
);
    localparam int IDXW = $clog2(WORDS);
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       line_q [WORDS];
    logic [31:0]       line_d [WORDS];

    logic              accept;
    logic [IDXW-1:0]   snoop_idx;
    logic              snoop_match;
    logic              unused_bits;

    assign accept = wb.evict_valid && (state_q == IDLE);

    // Offset bits are cleared when latching, so they never reach a register.
    assign unused_bits = ^{wb.evict_addr[IDXW+1:0], wb.snoop_addr[1:0]};

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            for (int i = 0; i < WORDS; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            for (int i = 0; i < WORDS; i++) begin
                line_q[i] <= line_d[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        for (int i = 0; i < WORDS; i++) begin
            line_d[i] = line_q[i];
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WRITE;
                    idx_d   = '0;
                    base_d  = {wb.evict_addr[ADDR_W-1:IDXW+2],
                               {(IDXW+2){1'b0}}};
                    for (int i = 0; i < WORDS; i++) begin
                        line_d[i] = wb.evict_data[32*i +: 32];
                    end
                end
            end
            WRITE: begin
                if (wb.mm_ack) begin
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        wb.evict_ready = 1'b0;
        wb.mm_we       = 1'b0;
        wb.mm_addr     = '0;
        wb.mm_din      = '0;
        wb.done        = 1'b0;
        wb.busy        = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                wb.evict_ready = 1'b1;
            end
            WRITE: begin
                wb.mm_we   = 1'b1;
                // Index lands in cleared low bits: no carry into the tag.
                wb.mm_addr = {base_q[ADDR_W-1:IDXW+2], idx_q, 2'b00};
                wb.mm_din  = line_q[idx_q];
            end
            DONE: begin
                wb.done = 1'b1;
            end
            default: begin
                wb.evict_ready = 1'b0;
            end
        endcase
    end

    // Snoop probe; still hits in DONE so a racing refill sees the line.
    assign snoop_idx   = wb.snoop_addr[IDXW+1:2];
    assign snoop_match = (wb.snoop_addr[ADDR_W-1:IDXW+2]
                          == base_q[ADDR_W-1:IDXW+2]);

    always_comb begin
        wb.snoop_hit  = (state_q != IDLE) && snoop_match;
        wb.snoop_data = '0;
        if (wb.snoop_hit) begin
            wb.snoop_data = line_q[snoop_idx];
        end
    end
endmodule

// File: tb/tb_dcache_writeback_buffer.sv
// Bench for dcache_writeback_buffer: line table with scoreboarded writes,
// snoop table, plus reset, latency and held-evict sequences.
module tb_dcache_writeback_buffer;
    localparam int WORDS  = 8;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #20 clk = ~clk;

    dcache_writeback_buffer_if #(.WORDS(WORDS), .ADDR_W(ADDR_W)) bus ();

    dcache_writeback_buffer #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .CLK (clk),
        .RST (rst),
        .wb  (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] seed;
        int          period;
        bit          snoop;
    } line_vec_t;

    typedef struct {
        logic [31:0] saddr;
        logic [31:0] hit;
        logic [31:0] data;
    } snoop_vec_t;

    int    total = 0;
    int    bad   = 0;
    beat_t sbq[$];
    beat_t mon_f;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] base_of(logic [31:0] a);
        return a & ~32'(WORDS * 4 - 1);
    endfunction

    task automatic push_line(logic [31:0] a, logic [31:0] seed);
        for (int i = 0; i < WORDS; i++) begin
            sbq.push_back('{addr: base_of(a) | 32'(i * 4),
                            data: seed + 32'(i)});
        end
    endtask

    task automatic drive_line(logic [31:0] a, logic [31:0] seed);
        bus.evict_addr = a;
        for (int i = 0; i < WORDS; i++) begin
            bus.evict_data[32*i +: 32] = seed + 32'(i);
        end
    endtask

    // Scoreboard: every write cycle must present the oldest pending word.
    always @(negedge clk) begin
        if (!rst && bus.mm_we) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h want none",
                         bus.mm_addr, bus.mm_din);
            end else begin
                mon_f = sbq[0];
                chk("mm_addr", bus.mm_addr, mon_f.addr);
                chk("mm_din", bus.mm_din, mon_f.data);
                if (bus.mm_ack) begin
                    void'(sbq.pop_front());
                end
            end
        end
    end

    line_vec_t  lines[4];
    snoop_vec_t snoops[6];

    // Called at posedge+1 with the buffer idle.
    task automatic run_line(line_vec_t v);
        int done_n;
        int ready_n;
        int dones;
        done_n  = 0;
        ready_n = 0;
        dones   = 0;
        chk("ready_before_line", 32'(bus.evict_ready), 1);
        push_line(v.addr, v.seed);
        drive_line(v.addr, v.seed);
        bus.snoop_addr  = base_of(v.addr) + 32'd4;
        bus.mm_ack      = 1'b0;
        bus.evict_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.evict_valid = 1'b0;
        for (int n = 1; n <= WORDS * v.period + 20; n++) begin
            bus.mm_ack = ((n % v.period) == 0);
            if (v.snoop && n == 3) begin
                for (int s = 0; s < 6; s++) begin
                    bus.snoop_addr = snoops[s].saddr;
                    #1;
                    chk("snoop_hit_tbl", 32'(bus.snoop_hit), snoops[s].hit);
                    chk("snoop_data_tbl", bus.snoop_data, snoops[s].data);
                end
                bus.snoop_addr = base_of(v.addr) + 32'd4;
            end
            @(negedge clk);
            if (bus.done) begin
                dones++;
                done_n = n;
                chk("done_cycle_we", 32'(bus.mm_we), 0);
                chk("done_cycle_busy", 32'(bus.busy), 1);
                chk("done_snoop_hit", 32'(bus.snoop_hit), 1);
                chk("done_snoop_data", bus.snoop_data, v.seed + 32'd1);
            end
            if (bus.evict_ready) begin
                ready_n = n;
                chk("idle_snoop_hit", 32'(bus.snoop_hit), 0);
                chk("idle_snoop_data", bus.snoop_data, 0);
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("done_latency", 32'(done_n), 32'(WORDS * v.period + 1));
        chk("ready_latency", 32'(ready_n), 32'(WORDS * v.period + 2));
        chk("done_pulses", 32'(dones), 1);
        chk("sb_empty", 32'(sbq.size()), 0);
        @(posedge clk);
        #1;
        bus.mm_ack = 1'b0;
    endtask

    initial begin
        int ready_n;
        ready_n = 0;

        lines[0] = '{addr: 32'h0000_1234, seed: 32'h0000_00A0,
                     period: 1, snoop: 1'b0};
        lines[1] = '{addr: 32'h0000_1220, seed: 32'h0000_00A0,
                     period: 8, snoop: 1'b1};
        lines[2] = '{addr: 32'hFFFF_FFFF, seed: 32'hDEAD_0000,
                     period: 1, snoop: 1'b0};
        lines[3] = '{addr: 32'h0000_0007, seed: 32'h1111_0000,
                     period: 3, snoop: 1'b0};

        snoops[0] = '{saddr: 32'h0000_122B, hit: 1, data: 32'hA2};
        snoops[1] = '{saddr: 32'h0000_1240, hit: 0, data: 32'h0};
        snoops[2] = '{saddr: 32'h0000_1220, hit: 1, data: 32'hA0};
        snoops[3] = '{saddr: 32'h0000_123F, hit: 1, data: 32'hA7};
        snoops[4] = '{saddr: 32'h0000_121F, hit: 0, data: 32'h0};
        snoops[5] = '{saddr: 32'h0000_1230, hit: 1, data: 32'hA4};

        bus.evict_valid = 1'b0;
        bus.evict_addr  = '0;
        bus.evict_data  = '0;
        bus.mm_ack      = 1'b0;
        bus.snoop_addr  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.evict_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;

        // Idle after reset with nothing presented.
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("idle_ready", 32'(bus.evict_ready), 1);
            chk("idle_we", 32'(bus.mm_we), 0);
            chk("idle_busy", 32'(bus.busy), 0);
            chk("idle_done", 32'(bus.done), 0);
            chk("idle_hit", 32'(bus.snoop_hit), 0);
            chk("idle_addr", bus.mm_addr, 0);
            chk("idle_din", bus.mm_din, 0);
        end
        @(posedge clk);
        #1;

        for (int t = 0; t < 4; t++) begin
            run_line(lines[t]);
        end

        // Evict held high during WRITE: second line waits for IDLE.
        push_line(32'h0000_2000, 32'h0000_0100);
        push_line(32'h0000_3004, 32'h0000_0200);
        drive_line(32'h0000_2000, 32'h0000_0100);
        bus.mm_ack      = 1'b1;
        bus.evict_valid = 1'b1;
        @(posedge clk);
        #1;
        drive_line(32'h0000_3004, 32'h0000_0200);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (bus.evict_ready) begin
                ready_n = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("held_accept_cycle", 32'(ready_n), 32'(WORDS + 2));
        @(posedge clk);
        #1;
        bus.evict_valid = 1'b0;
        ready_n = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (bus.evict_ready) begin
                ready_n = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("second_line_ready", 32'(ready_n), 32'(WORDS + 2));
        chk("second_line_sb", 32'(sbq.size()), 0);
        @(posedge clk);
        #1;

        // Reset in the middle of a line, after word 3 has been accepted.
        push_line(32'h0000_4000, 32'h0000_0300);
        drive_line(32'h0000_4000, 32'h0000_0300);
        bus.mm_ack      = 1'b1;
        bus.evict_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.evict_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_we", 32'(bus.mm_we), 1);
        chk("pre_rst_addr", bus.mm_addr, 32'h0000_4010);
        chk("pre_rst_sb", 32'(sbq.size()), 4);
        sbq.delete();
        rst = 1'b1;
        #1;
        chk("async_rst_we", 32'(bus.mm_we), 0);
        chk("async_rst_busy", 32'(bus.busy), 0);
        chk("async_rst_ready", 32'(bus.evict_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("post_rst_we", 32'(bus.mm_we), 0);
            chk("post_rst_busy", 32'(bus.busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
